// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: request and transmitter signals shared between the
// byte producers, the arbiter and the UART transmitter.
//   slave  : the arbiter's view (accepts requests and drives the transmitter)
//   master : the environment's view (producers plus transmitter)
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   ack;
    logic               tx_wr_en;
    logic [7:0]         tx_din;
    logic               tx_busy;

    modport slave (
        input  req, req_data, tx_busy,
        output ack, tx_wr_en, tx_din
    );

    modport master (
        output req, req_data, tx_busy,
        input  ack, tx_wr_en, tx_din
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte producers
// with round-robin arbitration, follows the transmitter busy flag through
// each frame, and generates the transmitter's baud enable tick.
// Optional macro UART_ARB_HDR_EN: each grant sends a header byte
// (8'hA0 | requester index) followed by the data byte.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int CLK_DIV = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              t_clk,
    input  logic              t_rst,
    uart_tx_arbiter_if.slave  bus,
    output logic              baud_tick,
    output logic [ID_W-1:0]   owner,
    output logic              arb_busy,
    output logic              err
);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   cand;
    logic              found;
    logic [BAUD_W-1:0] baud_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [7:0]        req_byte [N_REQ];
`ifdef UART_ARB_HDR_EN
    logic [7:0]        hold;
    logic              phase;   // 0: header frame in flight, 1: data frame
`endif

    // Split the flat request data bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_byte[i] = bus.req_data[8*i +: 8];
        end
    end

    // Round-robin pick: first requester after last_grant, wrapping; the
    // last candidate visited is last_grant itself.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = last_grant + ID_W'(i);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Free-running baud divider, independent of the arbiter state.
    always_ff @(posedge t_clk or posedge t_rst) begin
        if (t_rst) begin
            baud_cnt <= '0;
        end else if (baud_cnt == BAUD_W'(CLK_DIV - 1)) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    assign baud_tick = (baud_cnt == BAUD_W'(CLK_DIV - 1));
    assign arb_busy  = (state != IDLE);

`ifdef UART_ARB_HDR_EN
    // Keep the granted data byte while the header frame goes out.
    always_ff @(posedge t_clk) begin
        if (state == IDLE && found) begin
            hold <= req_byte[grant];
        end
    end
`endif

    // Arbiter FSM with registered strobes; ack, tx_wr_en and err default low
    // so each is a single-cycle pulse.
    always_ff @(posedge t_clk or posedge t_rst) begin
        if (t_rst) begin
            state        <= IDLE;
            bus.ack      <= '0;
            bus.tx_wr_en <= 1'b0;
            bus.tx_din   <= 8'h00;
            owner        <= '0;
            err          <= 1'b0;
            last_grant   <= ID_W'(N_REQ - 1);
            tmo_cnt      <= '0;
`ifdef UART_ARB_HDR_EN
            phase        <= 1'b0;
`endif
        end else begin
            bus.ack      <= '0;
            bus.tx_wr_en <= 1'b0;
            err          <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.ack      <= N_REQ'(1) << grant;
                        bus.tx_wr_en <= 1'b1;
                        owner        <= grant;
                        tmo_cnt      <= '0;
                        state        <= WAIT_BUSY;
`ifdef UART_ARB_HDR_EN
                        bus.tx_din   <= 8'hA0 | 8'(grant);
                        phase        <= 1'b0;
`else
                        bus.tx_din   <= req_byte[grant];
`endif
                    end
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        // Transmitter never started: abandon the grant
                        // (in header mode the held data byte is dropped).
                        err        <= 1'b1;
                        last_grant <= owner;
                        state      <= IDLE;
`ifdef UART_ARB_HDR_EN
                        phase      <= 1'b0;
`endif
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
`ifdef UART_ARB_HDR_EN
                        if (!phase) begin
                            // Header done: send the data byte without
                            // passing through IDLE.
                            bus.tx_din   <= hold;
                            bus.tx_wr_en <= 1'b1;
                            phase        <= 1'b1;
                            tmo_cnt      <= '0;
                            state        <= WAIT_BUSY;
                        end else begin
                            last_grant <= owner;
                            phase      <= 1'b0;
                            state      <= IDLE;
                        end
`else
                        last_grant <= owner;
                        state      <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter. Producers push
// bytes into per-requester queues; a monitor predicts each grant with a
// round-robin model and checks strobes, acks, bytes, error timing and ticks.
module tb_uart_tx_arbiter;
    localparam int N       = 4;
    localparam int ID_W    = 2;
    localparam int CLK_DIV = 16;
    localparam int TMO     = 64;

    logic            t_clk = 1'b0;
    logic            t_rst = 1'b0;
    logic            baud_tick;
    logic            arb_busy;
    logic            err;
    logic [ID_W-1:0] owner;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(
        .N_REQ(N), .ID_W(ID_W), .CLK_DIV(CLK_DIV), .TIMEOUT(TMO)
    ) dut (
        .t_clk(t_clk),
        .t_rst(t_rst),
        .bus(bus),
        .baud_tick(baud_tick),
        .owner(owner),
        .arb_busy(arb_busy),
        .err(err)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [7:0] stim_q [N][$];   // bytes still to be offered per requester
    logic [7:0] exp_q  [N][$];   // bytes offered, awaiting their grant
    int         grant_log[$];
    logic [7:0] din_log[$];
    bit         xmit_en = 1'b1;
    bit         rand_tx = 1'b0;
    int         err_seen = 0;

    initial forever #5 t_clk = ~t_clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic bit all_q_empty();
        for (int i = 0; i < N; i++)
            if (stim_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int max_cyc);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            @(posedge t_clk); #1;
            n++;
            done = (bus.req == '0) && !arb_busy && !bus.tx_busy && all_q_empty();
        end
        chk("wait_idle", done, 1);
    endtask

    // Producers: offer the next queued byte whenever req is low; drop req
    // after ack (re-raising at once when another byte is queued).
    initial begin
        logic [7:0] b;
        bus.req      = '0;
        bus.req_data = '0;
        forever begin
            @(negedge t_clk);
            for (int i = 0; i < N; i++) begin
                if (bus.ack[i] && bus.req[i]) bus.req[i] = 1'b0;
                if (!bus.req[i] && stim_q[i].size() > 0) begin
                    b = stim_q[i].pop_front();
                    bus.req_data[8*i +: 8] = b;
                    exp_q[i].push_back(b);
                    bus.req[i] = 1'b1;
                end
            end
        end
    end

    // Transmitter model: busy for a while shortly after each strobe.
    initial begin
        int d, l;
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge t_clk); #1;
            if (bus.tx_wr_en && xmit_en && !t_rst) begin
                d = rand_tx ? int'($urandom_range(1, 4)) : 2;
                l = rand_tx ? int'($urandom_range(1, 25)) : 20;
                repeat (d) @(negedge t_clk);
                bus.tx_busy = 1'b1;
                repeat (l) @(negedge t_clk);
                bus.tx_busy = 1'b0;
            end
        end
    end

    // Monitor and reference model.
    initial begin
        int edge_n, age, win, mlast, mwin;
        bit tmo_exp, mphase;
        logic [7:0] eb, mhold;
        edge_n = 0; age = 0; mlast = N - 1; mwin = 0;
        tmo_exp = 1'b0; mphase = 1'b0; mhold = '0;
        forever begin
            @(posedge t_clk); #1;
            if (t_rst) begin
                edge_n = 0; mlast = N - 1; mphase = 1'b0; tmo_exp = 1'b0; age = 0;
            end else begin
                edge_n++;
                age++;
                if (baud_tick || (edge_n % CLK_DIV == CLK_DIV - 1))
                    chk("baud_tick", baud_tick, (edge_n % CLK_DIV == CLK_DIV - 1));
                if (tmo_exp && age == TMO) begin
                    chk("err_at_timeout", err, 1);
                    tmo_exp = 1'b0;
                    mphase = 1'b0;
                end else if (err) begin
                    chk("err_spurious", err, 0);
                end
                if (err) err_seen++;
                if (bus.ack != '0) grant_log.push_back(int'(owner));
                if (bus.tx_wr_en) begin
                    din_log.push_back(bus.tx_din);
                    chk("strobe_while_busy", bus.tx_busy, 0);
                    chk("arb_busy_on_strobe", arb_busy, 1);
                    age = 0;
                    tmo_exp = !xmit_en;
                    if (!mphase) begin
                        win = -1;
                        for (int k = 1; k <= N; k++)
                            if (win < 0 && bus.req[(mlast + k) % N]) win = (mlast + k) % N;
                        if (win < 0 || exp_q[win < 0 ? 0 : win].size() == 0) begin
                            chk("strobe_unrequested", bus.tx_wr_en, 0);
                        end else begin
                            eb = exp_q[win].pop_front();
                            mlast = win;
                            mwin = win;
                            chk("ack_onehot", bus.ack, 32'(1) << win);
                            chk("owner", owner, win);
`ifdef UART_ARB_HDR_EN
                            mhold = eb;
                            mphase = 1'b1;
                            chk("tx_din_hdr", bus.tx_din, 32'hA0 | win);
`else
                            chk("tx_din", bus.tx_din, eb);
`endif
                        end
                    end else begin
                        mphase = 1'b0;
                        chk("ack_data_phase", bus.ack, 0);
                        chk("owner_data", owner, mwin);
                        chk("tx_din_data", bus.tx_din, mhold);
                    end
                end else if (bus.ack != '0) begin
                    chk("ack_without_strobe", bus.ack, 0);
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int rr_exp[5] = '{0, 1, 2, 3, 0};
        int e0, ri;

        #2 t_rst = 1'b1;
        repeat (3) @(posedge t_clk);
        #1;
        chk("rst_ack", bus.ack, 0);
        chk("rst_wr_en", bus.tx_wr_en, 0);
        chk("rst_err", err, 0);
        chk("rst_din", bus.tx_din, 0);
        chk("rst_owner", owner, 0);
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_baud", baud_tick, 0);
        @(negedge t_clk);
        t_rst = 1'b0;

        // Idle: only baud ticks should appear.
        repeat (40) @(posedge t_clk);
        #1;
        chk("idle_arb_busy", arb_busy, 0);
        chk("idle_wr_en", bus.tx_wr_en, 0);

        // All four requesting: strict rotation starting at requester 0.
        @(posedge t_clk); #3;
        grant_log.delete();
        stim_q[0].push_back(8'h11);
        stim_q[1].push_back(8'h22);
        stim_q[2].push_back(8'h33);
        stim_q[3].push_back(8'h44);
        stim_q[0].push_back(8'h55);
        wait_idle(1000);
        chk("rr_count", grant_log.size(), 5);
        if (grant_log.size() == 5)
            for (int i = 0; i < 5; i++) chk("rr_order", grant_log[i], rr_exp[i]);

        // Single request from requester 2.
        @(posedge t_clk); #3;
        grant_log.delete();
        din_log.delete();
        stim_q[2].push_back(8'h5A);
        wait_idle(300);
        chk("single_grants", grant_log.size(), 1);
        if (grant_log.size() >= 1) chk("single_owner_log", grant_log[0], 2);
        chk("owner_held_idle", owner, 2);
        chk("single_arb_idle", arb_busy, 0);
`ifdef UART_ARB_HDR_EN
        chk("single_strobes", din_log.size(), 2);
        if (din_log.size() == 2) begin
            chk("single_hdr_byte", din_log[0], 8'hA2);
            chk("single_data_byte", din_log[1], 8'h5A);
        end
`else
        chk("single_strobes", din_log.size(), 1);
        if (din_log.size() == 1) chk("single_data_byte", din_log[0], 8'h5A);
`endif

        // Transmitter dead: both grants time out, 1 then 2.
        xmit_en = 1'b0;
        e0 = err_seen;
        @(posedge t_clk); #3;
        grant_log.delete();
        stim_q[1].push_back(8'($urandom));
        stim_q[2].push_back(8'($urandom));
        wait_idle(500);
        chk("timeout_err_count", err_seen - e0, 2);
        chk("timeout_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("timeout_first", grant_log[0], 1);
            chk("timeout_second", grant_log[1], 2);
        end
        xmit_en = 1'b1;

        // Randomized traffic with random transmitter timing.
        rand_tx = 1'b1;
        repeat (60) begin
            repeat ($urandom_range(1, 30)) @(posedge t_clk);
            #3;
            ri = int'($urandom_range(0, N - 1));
            stim_q[ri].push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) stim_q[(ri + 1) % N].push_back(8'($urandom));
        end
        wait_idle(9000);
        rand_tx = 1'b0;

        // Reset in the middle of a frame, with 0 and 3 waiting.
        @(posedge t_clk); #3;
        stim_q[2].push_back(8'h77);
        begin
            int n;
            n = 0;
            while (!bus.tx_busy && n < 50) begin
                @(posedge t_clk); #1;
                n++;
            end
        end
        chk("busy_rose", bus.tx_busy, 1);
        #2;
        stim_q[3].push_back(8'h3C);
        stim_q[0].push_back(8'h0C);
        repeat (4) @(posedge t_clk);
        #3;
        t_rst = 1'b1;
        #1;
        chk("midrst_ack", bus.ack, 0);
        chk("midrst_wr_en", bus.tx_wr_en, 0);
        chk("midrst_err", err, 0);
        chk("midrst_din", bus.tx_din, 0);
        chk("midrst_owner", owner, 0);
        chk("midrst_arb_busy", arb_busy, 0);
        chk("midrst_baud", baud_tick, 0);
        grant_log.delete();
        repeat (30) @(negedge t_clk);
        t_rst = 1'b0;
        wait_idle(400);
        chk("post_rst_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("post_rst_first", grant_log[0], 0);
            chk("post_rst_second", grant_log[1], 3);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
